// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame transmitter.
// Holds the frame FSM encoding, line levels and the counter-width helper.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } frame_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: bit_end is high on the last clock of every BIT_CYCLES-long bit.
// A restart pulse re-aligns the period so that a new frame starts a fresh bit.
module serial_bit_timer
    import serial_frame_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_end
);

    localparam int unsigned CNT_W = cnt_width(BIT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 32'd1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             bit_end_r;

    // Next count: restart or wrap to zero, otherwise advance.
    always_comb begin
        cnt_s = cnt_r;
        if (restart) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (cnt_r == LAST_CNT) begin
            cnt_s = {CNT_W{1'b0}};
        end else begin
            cnt_s = cnt_r + CNT_W'(1);
        end
    end

    // Count register; bit_end is registered from the next count so it aligns with cnt_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= {CNT_W{1'b0}};
            bit_end_r <= (LAST_CNT == {CNT_W{1'b0}});
        end else begin
            cnt_r     <= cnt_s;
            bit_end_r <= (cnt_s == LAST_CNT);
        end
    end

    assign bit_end = bit_end_r;

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: one-word holding buffer, shift register and
// frame FSM producing start bit, DATA_W data bits LSB-first and a stop bit.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              s_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W = cnt_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 32'd1);

    frame_state_e      state_r;
    frame_state_e      state_s;
    logic [DATA_W-1:0] buf_data_r;
    logic              buf_full_r;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_s;
    logic [IDX_W-1:0]  bit_idx_r;
    logic [IDX_W-1:0]  bit_idx_s;
    logic              s_out_r;
    logic              s_out_s;
    logic              busy_r;
    logic              done_r;
    logic              done_s;
    logic              load_s;
    logic              accept_s;
    logic              bit_end_s;

    assign accept_s = in_valid && !buf_full_r;

    serial_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (load_s),
        .bit_end (bit_end_s)
    );

    // Frame FSM: next state, shifter, bit index and the next serial line level.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_idx_s = bit_idx_r;
        s_out_s   = s_out_r;
        done_s    = 1'b0;
        load_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (buf_full_r) begin
                    load_s  = 1'b1;
                    state_s = START;
                    shift_s = buf_data_r;
                    s_out_s = START_LEVEL;
                end else begin
                    s_out_s = IDLE_LEVEL;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s   = DATA;
                    bit_idx_s = {IDX_W{1'b0}};
                    s_out_s   = shift_r[0];
                end else begin
                    s_out_s = START_LEVEL;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_r == LAST_IDX) begin
                        state_s = STOP;
                        s_out_s = IDLE_LEVEL;
                    end else begin
                        bit_idx_s = bit_idx_r + IDX_W'(1);
                        shift_s   = shift_r >> 1;
                        s_out_s   = shift_s[0];
                    end
                end else begin
                    s_out_s = shift_r[0];
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    done_s = 1'b1;
                    // A waiting word starts immediately so frames run back-to-back.
                    if (buf_full_r) begin
                        load_s  = 1'b1;
                        state_s = START;
                        shift_s = buf_data_r;
                        s_out_s = START_LEVEL;
                    end else begin
                        state_s = IDLE;
                        s_out_s = IDLE_LEVEL;
                    end
                end else begin
                    s_out_s = IDLE_LEVEL;
                end
            end
            default: begin
                state_s = IDLE;
                s_out_s = IDLE_LEVEL;
            end
        endcase
    end

    // Holding buffer: filled on accept, emptied on load; the two never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full_r <= 1'b0;
            buf_data_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            buf_full_r <= 1'b1;
            buf_data_r <= in_data;
        end else if (load_s) begin
            buf_full_r <= 1'b0;
        end else begin
            buf_full_r <= buf_full_r;
        end
    end

    // FSM state, shifter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            shift_r   <= {DATA_W{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            s_out_r   <= IDLE_LEVEL;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_idx_r <= bit_idx_s;
            s_out_r   <= s_out_s;
            busy_r    <= (state_s != IDLE);
            done_r    <= done_s;
        end
    end

    assign in_ready = !buf_full_r;
    assign s_out    = s_out_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
